spi_bus_arbiter: RTL and testbench

- Shares the single board SPI bus (SCK/MOSI/MISO) between up to NUM_REQ masters: OLED engine, uSD loader, VS1053 audio feeder, APP/DES flash.
- Round-robin request/grant arbitration. The winner's SCK/MOSI/chip-select are muxed onto the pins.
- Sits between the core's SPI masters and the top-level pads; a guard gap with all selects high separates owners.

---
 rtl/spi_bus_arbiter_if.sv | 30 +++
 rtl/spi_bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_arbiter_if.sv
// Bus bundle between the SPI masters and the pad arbiter.
// slave = arbiter view, master = requester/pad view.
interface spi_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
);
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic [NUM_REQ-1:0] sck_i;
  logic [NUM_REQ-1:0] mosi_i;
  logic [NUM_REQ-1:0] cs_n_i;
  logic               miso_i;
  logic               sck_o;
  logic               mosi_o;
  logic [NUM_REQ-1:0] cs_n_o;
  logic [NUM_REQ-1:0] miso_o;
  logic               busy_o;
  logic [IDX_W-1:0]   owner_o;
  logic               timeout_o;

  modport slave (
    input  req_i, sck_i, mosi_i, cs_n_i, miso_i,
    output gnt_o, sck_o, mosi_o, cs_n_o, miso_o, busy_o, owner_o, timeout_o
  );

  modport master (
    output req_i, sck_i, mosi_i, cs_n_i, miso_i,
    input  gnt_o, sck_o, mosi_o, cs_n_o, miso_o, busy_o, owner_o, timeout_o
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the shared SPI pads with a CS-high guard gap between owners.
// Optional grant timeout enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned IDX_W          = 2,
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter logic        SCK_IDLE       = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  spi_bus_arbiter_if.slave  bus
);

  localparam int unsigned GRD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [GRD_W-1:0]   r_guard_cnt;
  logic               r_busy;
  logic               r_timeout;

  logic [NUM_REQ-1:0] w_req_elig;
  logic               w_pick_vld;
  logic [IDX_W-1:0]   w_pick;
  logic [IDX_W-1:0]   w_next_ptr;
  logic               w_owner_req;
  logic               w_tmo_hit;
  logic               w_tmo_fire;
  logic               w_sck;
  logic               w_mosi;
  logic [NUM_REQ-1:0] w_cs_n;
  logic [NUM_REQ-1:0] w_miso;

  // First eligible request at or above rr_ptr, else the lowest one below it.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!w_pick_vld && w_req_elig[j] && (32'(r_rr_ptr) <= j)) begin
        w_pick_vld = 1'b1;
        w_pick     = IDX_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!w_pick_vld && w_req_elig[j]) begin
        w_pick_vld = 1'b1;
        w_pick     = IDX_W'(j);
      end
    end
  end

  assign w_next_ptr = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

  // Pad mux driven from the registered owner; pads idle outside GRANT.
  always_comb begin
    w_owner_req = 1'b0;
    w_sck       = SCK_IDLE;
    w_mosi      = 1'b0;
    w_cs_n      = '1;
    w_miso      = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (r_owner == IDX_W'(j)) begin
        w_owner_req = bus.req_i[j];
        if (r_state == ST_GRANT) begin
          w_sck     = bus.sck_i[j];
          w_mosi    = bus.mosi_i[j];
          w_cs_n[j] = bus.cs_n_i[j];
          w_miso[j] = bus.miso_i;
        end
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [NUM_REQ-1:0] r_tmo_block;
  logic [NUM_REQ-1:0] w_req_unblk;

  assign w_tmo_hit   = (r_state == ST_GRANT) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_req_unblk = bus.req_i & ~r_tmo_block;
  // A timed-out master only competes again once nobody else is waiting.
  assign w_req_elig  = (w_req_unblk != '0) ? w_req_unblk : bus.req_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tmo_cnt   <= '0;
      r_tmo_block <= '0;
    end else begin
      if (r_state != ST_GRANT || w_tmo_hit) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
      if (w_tmo_fire) begin
        r_tmo_block <= (r_tmo_block & bus.req_i) | (NUM_REQ'(1) << r_owner);
      end else if (r_state == ST_IDLE && w_pick_vld) begin
        r_tmo_block <= r_tmo_block & bus.req_i & ~(NUM_REQ'(1) << w_pick);
      end else begin
        r_tmo_block <= r_tmo_block & bus.req_i;
      end
    end
  end
`else
  assign w_tmo_hit  = 1'b0;
  assign w_req_elig = bus.req_i;
`endif

  assign w_tmo_fire = (r_state == ST_GRANT) && w_tmo_hit && w_owner_req;

  // Arbiter FSM with registered grant, owner, busy and timeout pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_guard_cnt <= '0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_state <= ST_GRANT;
            r_gnt   <= NUM_REQ'(1) << w_pick;
            r_owner <= w_pick;
            r_busy  <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (!w_owner_req || w_tmo_hit) begin
            r_state     <= ST_GUARD;
            r_gnt       <= '0;
            r_rr_ptr    <= w_next_ptr;
            r_guard_cnt <= GRD_W'(GUARD_CYCLES - 1);
            r_timeout   <= w_tmo_fire;
          end
        end
        ST_GUARD: begin
          if (r_guard_cnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_guard_cnt <= r_guard_cnt - GRD_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_o     = r_gnt;
  assign bus.owner_o   = r_owner;
  assign bus.busy_o    = r_busy;
  assign bus.timeout_o = r_timeout;
  assign bus.sck_o     = w_sck;
  assign bus.mosi_o    = w_mosi;
  assign bus.cs_n_o    = w_cs_n;
  assign bus.miso_o    = w_miso;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: reset, round-robin order, guard gap, pad mux, async reset.
// The timeout section only runs when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_bus_arbiter;

  logic clk_i;
  logic rst_n_i;
  int   n_vec;
  int   n_err;

  spi_bus_arbiter_if #(.NUM_REQ(4), .IDX_W(2)) bus ();

  spi_bus_arbiter #(
    .NUM_REQ       (4),
    .IDX_W         (2),
    .GUARD_CYCLES  (4),
    .SCK_IDLE      (1'b0),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .bus    (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Owner releases on the next edge; checks the 4-cycle guard, the idle cycle and the next grant.
  task automatic guard_then(input logic [3:0] req_drop, input logic [3:0] req_after,
                            input logic [3:0] exp_gnt, input logic [1:0] exp_owner,
                            input logic [1:0] old_owner, input string tag);
    bus.req_i = req_drop;
    step();
    bus.req_i = req_after;
    chk({tag, "_drop_gnt"},   8'(bus.gnt_o), 8'h0);
    chk({tag, "_drop_busy"},  8'(bus.busy_o), 8'h1);
    chk({tag, "_drop_cs"},    8'(bus.cs_n_o), 8'hF);
    chk({tag, "_drop_owner"}, 8'(bus.owner_o), 8'(old_owner));
    repeat (3) begin
      step();
      chk({tag, "_guard_busy"}, 8'(bus.busy_o), 8'h1);
      chk({tag, "_guard_gnt"},  8'(bus.gnt_o), 8'h0);
      chk({tag, "_guard_cs"},   8'(bus.cs_n_o), 8'hF);
    end
    step();
    chk({tag, "_idle_busy"}, 8'(bus.busy_o), 8'h0);
    chk({tag, "_idle_gnt"},  8'(bus.gnt_o), 8'h0);
    step();
    chk({tag, "_next_gnt"},   8'(bus.gnt_o), 8'(exp_gnt));
    chk({tag, "_next_owner"}, 8'(bus.owner_o), 8'(exp_owner));
    chk({tag, "_next_busy"},  8'(bus.busy_o), 8'(|exp_gnt));
  endtask

  initial begin
    logic [3:0] cur;
    logic [3:0] nxt;
    n_vec = 0;
    n_err = 0;
    rst_n_i     = 1'b0;
    bus.req_i   = 4'b1111;
    bus.sck_i   = 4'b0000;
    bus.mosi_i  = 4'b0000;
    bus.cs_n_i  = 4'b1111;
    bus.miso_i  = 1'b0;

    // Reset with all requests high.
    #2;
    chk("rst_gnt",   8'(bus.gnt_o), 8'h0);
    chk("rst_cs",    8'(bus.cs_n_o), 8'hF);
    chk("rst_sck",   8'(bus.sck_o), 8'h0);
    chk("rst_busy",  8'(bus.busy_o), 8'h0);
    chk("rst_owner", 8'(bus.owner_o), 8'h0);
    chk("rst_tmo",   8'(bus.timeout_o), 8'h0);
    step();
    step();
    rst_n_i = 1'b1;
    step();
    chk("first_gnt",   8'(bus.gnt_o), 8'h1);
    chk("first_owner", 8'(bus.owner_o), 8'h0);
    chk("first_busy",  8'(bus.busy_o), 8'h1);

    // All four requesting: order 0,1,2,3,0 with re-asserted owner losing.
    for (int k = 0; k < 4; k++) begin
      cur = 4'b0001 << k;
      nxt = 4'b0001 << ((k + 1) % 4);
      repeat (9) step();
      chk("rr_hold_gnt", 8'(bus.gnt_o), 8'(cur));
      guard_then(4'b1111 & ~cur, 4'b1111, nxt, 2'((k + 1) % 4), 2'(k), "rr");
    end

    // Everyone drops; then requester 2 alone and the pad mux follows it.
    guard_then(4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd0, "alldrop");
    bus.req_i = 4'b0100;
    step();
    chk("r2_gnt",   8'(bus.gnt_o), 8'h4);
    chk("r2_owner", 8'(bus.owner_o), 8'h2);
    bus.cs_n_i = 4'b1011;
    bus.sck_i  = 4'b0100;
    bus.mosi_i = 4'b0100;
    bus.miso_i = 1'b1;
    #1;
    chk("mux_cs",   8'(bus.cs_n_o), 8'hB);
    chk("mux_sck1", 8'(bus.sck_o), 8'h1);
    chk("mux_mosi1",8'(bus.mosi_o), 8'h1);
    chk("mux_miso", 8'(bus.miso_o), 8'h4);
    bus.sck_i  = 4'b1011;
    bus.mosi_i = 4'b1011;
    bus.miso_i = 1'b0;
    #1;
    chk("mux_sck0",  8'(bus.sck_o), 8'h0);
    chk("mux_mosi0", 8'(bus.mosi_o), 8'h0);
    chk("mux_miso0", 8'(bus.miso_o), 8'h0);
    bus.sck_i = 4'b0100;
    #1;

    // Asynchronous reset mid-grant of owner 2.
    rst_n_i = 1'b0;
    #1;
    chk("arst_gnt",   8'(bus.gnt_o), 8'h0);
    chk("arst_cs",    8'(bus.cs_n_o), 8'hF);
    chk("arst_sck",   8'(bus.sck_o), 8'h0);
    chk("arst_busy",  8'(bus.busy_o), 8'h0);
    chk("arst_owner", 8'(bus.owner_o), 8'h0);
    bus.req_i  = 4'b0011;
    bus.cs_n_i = 4'b1111;
    bus.sck_i  = 4'b0000;
    bus.mosi_i = 4'b0000;
    step();
    rst_n_i = 1'b1;
    step();
    chk("arst_rrptr_gnt", 8'(bus.gnt_o), 8'h1);

    // Owner 1 drops while request 3 rises in the same cycle.
    guard_then(4'b0010, 4'b0010, 4'b0010, 2'd1, 2'd0, "to1");
    step();
    guard_then(4'b1000, 4'b1000, 4'b1000, 2'd3, 2'd1, "drop1_rise3");
    guard_then(4'b0000, 4'b0000, 4'b0000, 2'd3, 2'd3, "drop3");

    // One-cycle request pulse still gets a one-cycle grant.
    bus.req_i = 4'b0001;
    step();
    chk("pulse_gnt", 8'(bus.gnt_o), 8'h1);
    guard_then(4'b0000, 4'b0100, 4'b0100, 2'd2, 2'd0, "pulse");

    // Lone requester is re-granted after the guard.
    guard_then(4'b0000, 4'b0100, 4'b0100, 2'd2, 2'd2, "single");
    chk("no_tmo", 8'(bus.timeout_o), 8'h0);

`ifdef SPI_ARB_TIMEOUT_EN
    guard_then(4'b0000, 4'b0000, 4'b0000, 2'd2, 2'd2, "pre_tmo");
    bus.req_i = 4'b0001;
    step();
    chk("tmo_gnt0", 8'(bus.gnt_o), 8'h1);
    bus.req_i = 4'b0011;
    repeat (15) step();
    chk("tmo_hold_gnt", 8'(bus.gnt_o), 8'h1);
    chk("tmo_hold_pls", 8'(bus.timeout_o), 8'h0);
    step();
    chk("tmo_drop_gnt", 8'(bus.gnt_o), 8'h0);
    chk("tmo_pulse",    8'(bus.timeout_o), 8'h1);
    step();
    chk("tmo_pulse_end", 8'(bus.timeout_o), 8'h0);
    repeat (3) step();
    chk("tmo_idle_gnt", 8'(bus.gnt_o), 8'h0);
    step();
    chk("tmo_next_gnt", 8'(bus.gnt_o), 8'h2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
